// File: rtl/host_bus_if_pkg.sv
// Shared types and constants for the host bus bridge.
package host_bus_if_pkg;

  localparam int unsigned VRAM_ADDR_W = 13;
  localparam int unsigned HOST_ADDR_W = 11;
  localparam int unsigned BANK_W      = 2;
  localparam int unsigned DATA_W      = 8;

  // External transceiver direction levels.
  localparam logic DIR_TO_FPGA = 1'b1;
  localparam logic DIR_TO_HOST = 1'b0;

  // Bridge FSM encoding.
  typedef enum logic [2:0] {
    StIdle     = 3'd0,
    StRdReq    = 3'd1,
    StRdCap    = 3'd2,
    StRdHold   = 3'd3,
    StWrHold   = 3'd4,
    StWrCommit = 3'd5
  } state_e;

  // Host window {bank, addr11} onto the 13-bit VRAM space; never wraps.
  function automatic logic [VRAM_ADDR_W-1:0] vram_addr(input logic [BANK_W-1:0]      bank,
                                                       input logic [HOST_ADDR_W-1:0] addr);
    return {bank, addr};
  endfunction

endpackage

// File: rtl/host_bus_if_sync_ff.sv
// Per-bit multi-stage synchroniser with asynchronous clear to a fixed level.
module sync_ff #(
  parameter int unsigned Stages   = 2,
  parameter logic        ResetVal = 1'b0
) (
  input  logic clk_i,
  input  logic rst_ni,
  input  logic d_i,
  output logic q_o
);

  logic [Stages-1:0] sync_q;
  logic [Stages-1:0] sync_d;

  // Shift the raw input one stage deeper each cycle.
  always_comb begin
    sync_d = {sync_q[Stages-2:0], d_i};
  end

  // Synchroniser chain, cleared to the inactive level.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      sync_q <= {Stages{ResetVal}};
    end else begin
      sync_q <= sync_d;
    end
  end

  assign q_o = sync_q[Stages-1];

endmodule

// File: rtl/host_bus_if.sv
// Asynchronous 8-bit host bus to VRAM host-port bridge with a 2-bit bank register.
module host_bus_if
  import host_bus_if_pkg::*;
#(
  parameter int unsigned      SYNC_STAGES = 2,
  parameter logic [BANK_W-1:0] BANK_RESET = 2'd0
) (
  input  logic                   clk,
  input  logic                   nrst,
  input  logic [HOST_ADDR_W-1:0] hostBusAddr,
  inout  wire  [DATA_W-1:0]      hostBusData,
  input  logic                   nHostRMEM,
  input  logic                   nHostWMEM,
  input  logic                   nHostVRAMEn,
  input  logic                   nHostBankRegEn,
  output logic                   hostBusDir,
  input  logic [DATA_W-1:0]      hostRdData,
  output logic                   hostSelect,
  output logic                   hostRd,
  output logic [VRAM_ADDR_W-1:0] hostAddr,
  output logic [DATA_W-1:0]      hostWrData
);

  // Raw request decode straight from the pins.
  logic rd_req_raw;
  logic wr_req_raw;
  logic tgt_vram_raw;
  logic any_en;

  assign any_en       = ~nHostVRAMEn | ~nHostBankRegEn;
  assign rd_req_raw   = ~nHostRMEM & any_en;
  assign wr_req_raw   = ~nHostWMEM & any_en;
  // VRAM wins when both selects are low.
  assign tgt_vram_raw = ~nHostVRAMEn;

  // Synchronised versions; only these steer the FSM.
  logic rd_s;
  logic wr_s;
  logic tgt_vram_s;

  sync_ff #(
    .Stages   (SYNC_STAGES),
    .ResetVal (1'b0)
  ) u_sync_rd (
    .clk_i  (clk),
    .rst_ni (nrst),
    .d_i    (rd_req_raw),
    .q_o    (rd_s)
  );

  sync_ff #(
    .Stages   (SYNC_STAGES),
    .ResetVal (1'b0)
  ) u_sync_wr (
    .clk_i  (clk),
    .rst_ni (nrst),
    .d_i    (wr_req_raw),
    .q_o    (wr_s)
  );

  sync_ff #(
    .Stages   (SYNC_STAGES),
    .ResetVal (1'b0)
  ) u_sync_tgt (
    .clk_i  (clk),
    .rst_ni (nrst),
    .d_i    (tgt_vram_raw),
    .q_o    (tgt_vram_s)
  );

  state_e                 state_q, state_d;
  logic [BANK_W-1:0]      bank_q, bank_d;
  logic [DATA_W-1:0]      rdbuf_q, rdbuf_d;
  logic [HOST_ADDR_W-1:0] addr_q, addr_d;
  logic [DATA_W-1:0]      data_q, data_d;
  // Write target held from the asserted phase, so selects released together
  // with the strobe cannot retarget a pending VRAM write to the bank register.
  logic                   wr_vram_q, wr_vram_d;

  // State register.
  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      state_q <= StIdle;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state decode.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle: begin
        if (rd_s && !wr_s) begin
          state_d = tgt_vram_s ? StRdReq : StRdHold;
        end else if (wr_s && !rd_s) begin
          state_d = StWrHold;
        end
      end
      StRdReq:  state_d = StRdCap;
      StRdCap:  state_d = StRdHold;
      StRdHold: begin
        if (!rd_s) begin
          state_d = StIdle;
        end
      end
      StWrHold: begin
        if (!wr_s) begin
          state_d = wr_vram_q ? StWrCommit : StIdle;
        end
      end
      StWrCommit: state_d = StIdle;
      default:    state_d = StIdle;
    endcase
  end

  // Datapath registers: bank, read buffer, write capture.
  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      bank_q    <= BANK_RESET;
      rdbuf_q   <= '0;
      addr_q    <= '0;
      data_q    <= '0;
      wr_vram_q <= 1'b0;
    end else begin
      bank_q    <= bank_d;
      rdbuf_q   <= rdbuf_d;
      addr_q    <= addr_d;
      data_q    <= data_d;
      wr_vram_q <= wr_vram_d;
    end
  end

  // Datapath next-state: read buffer loads, write sampling, bank update.
  always_comb begin
    bank_d    = bank_q;
    rdbuf_d   = rdbuf_q;
    addr_d    = addr_q;
    data_d    = data_q;
    wr_vram_d = wr_vram_q;
    unique case (state_q)
      StIdle: begin
        if (rd_s && !wr_s && !tgt_vram_s) begin
          rdbuf_d = {{(DATA_W - BANK_W){1'b0}}, bank_q};
        end
        if (wr_s && !rd_s) begin
          wr_vram_d = tgt_vram_s;
        end
      end
      StRdCap: begin
        rdbuf_d = hostRdData;
      end
      StWrHold: begin
        // Keep sampling; the last sample before release is what commits.
        addr_d = hostBusAddr;
        data_d = hostBusData;
        if (wr_s) begin
          wr_vram_d = tgt_vram_s;
        end else if (!wr_vram_q) begin
          bank_d = data_q[BANK_W-1:0];
        end
      end
      default: ;
    endcase
  end

  // VRAM host-port outputs, decoded from the state.
  always_comb begin
    hostSelect = 1'b0;
    hostRd     = 1'b1;
    hostAddr   = '0;
    hostWrData = '0;
    unique case (state_q)
      StRdReq: begin
        hostSelect = 1'b1;
        hostAddr   = vram_addr(bank_q, hostBusAddr);
      end
      StWrCommit: begin
        hostSelect = 1'b1;
        hostRd     = 1'b0;
        hostAddr   = vram_addr(bank_q, addr_q);
        hostWrData = data_q;
      end
      default: ;
    endcase
  end

  // Pin drive follows the raw strobe so the transceiver turns around at once.
  assign hostBusDir  = rd_req_raw ? DIR_TO_HOST : DIR_TO_FPGA;
  assign hostBusData = rd_req_raw ? rdbuf_q : {DATA_W{1'bz}};

endmodule

// File: tb/tb_host_bus_if.sv
// Directed bench for host_bus_if with a small VRAM host-port model.
module tb_host_bus_if;

  logic        clk = 1'b0;
  logic        nrst = 1'b0;
  logic [10:0] addr = '0;
  logic        n_rmem = 1'b1;
  logic        n_wmem = 1'b1;
  logic        n_vram_en = 1'b1;
  logic        n_bank_en = 1'b1;
  wire  [7:0]  bus;
  logic [7:0]  tb_data = '0;
  logic        tb_drv = 1'b0;
  logic        dir;
  logic [7:0]  rdata = '0;
  logic        sel;
  logic        rd;
  logic [12:0] haddr;
  logic [7:0]  wdata;

  int          checks = 0;
  int          failures = 0;
  int          sel_cnt = 0;
  logic [12:0] last_addr = '0;
  logic        last_rd = 1'b1;
  logic [7:0]  last_wdata = '0;

  assign bus = tb_drv ? tb_data : 8'hzz;

  always #5 clk = ~clk;

  host_bus_if #(
    .SYNC_STAGES (2),
    .BANK_RESET  (2'd0)
  ) dut (
    .clk            (clk),
    .nrst           (nrst),
    .hostBusAddr    (addr),
    .hostBusData    (bus),
    .nHostRMEM      (n_rmem),
    .nHostWMEM      (n_wmem),
    .nHostVRAMEn    (n_vram_en),
    .nHostBankRegEn (n_bank_en),
    .hostBusDir     (dir),
    .hostRdData     (rdata),
    .hostSelect     (sel),
    .hostRd         (rd),
    .hostAddr       (haddr),
    .hostWrData     (wdata)
  );

  // VRAM model: read data is addr[7:0]^0xA5, valid the cycle after select.
  always @(posedge clk) begin
    if (sel && rd) rdata <= haddr[7:0] ^ 8'hA5;
  end

  // Access monitor.
  always @(posedge clk) begin
    if (sel) begin
      sel_cnt    <= sel_cnt + 1;
      last_addr  <= haddr;
      last_rd    <= rd;
      last_wdata <= wdata;
    end
  end

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Host write cycle: strobe low 8 clk, then hold selects/data until committed.
  task automatic host_write(input logic vram_en, input logic bank_en,
                            input logic [10:0] a, input logic [7:0] d);
    n_vram_en = ~vram_en;
    n_bank_en = ~bank_en;
    addr      = a;
    tb_data   = d;
    tb_drv    = 1'b1;
    n_wmem    = 1'b0;
    tick(8);
    n_wmem    = 1'b1;
    tick(5);
    n_vram_en = 1'b1;
    n_bank_en = 1'b1;
    tb_drv    = 1'b0;
    tick(2);
  endtask

  // Host read cycle: sample bus and direction 6 clk after the strobe falls.
  task automatic host_read(input logic vram_en, input logic bank_en, input logic [10:0] a,
                           output logic [7:0] val, output logic dir_o);
    n_vram_en = ~vram_en;
    n_bank_en = ~bank_en;
    addr      = a;
    n_rmem    = 1'b0;
    tick(6);
    val       = bus;
    dir_o     = dir;
    n_rmem    = 1'b1;
    tick(4);
    n_vram_en = 1'b1;
    n_bank_en = 1'b1;
    tick(1);
  endtask

  logic [7:0] rv;
  logic       rdir;
  int         cnt0;
  logic       seen;

  initial begin
    tick(2);
    check("rst_sel", sel, 1'b0);
    check("rst_rd", rd, 1'b1);
    check("rst_addr", haddr, 13'h0000);
    check("rst_wdata", wdata, 8'h00);
    check("rst_dir", dir, 1'b1);
    nrst = 1'b1;
    tick(2);

    // Bank register write then read back over the host bus.
    host_write(1'b0, 1'b1, 11'h000, 8'h03);
    host_read(1'b0, 1'b1, 11'h000, rv, rdir);
    check("bank_rd_val", rv, 8'h03);
    check("bank_rd_dir", rdir, 1'b0);
    check("bank_no_sel", sel_cnt, 0);

    // VRAM write in bank 2 with exact commit timing.
    host_write(1'b0, 1'b1, 11'h000, 8'h02);
    cnt0      = sel_cnt;
    n_vram_en = 1'b0;
    addr      = 11'h155;
    tb_data   = 8'hA5;
    tb_drv    = 1'b1;
    n_wmem    = 1'b0;
    tick(8);
    n_wmem    = 1'b1;
    tick(2);
    check("wr_early_sel", sel, 1'b0);
    tick(1);
    check("wr_sel", sel, 1'b1);
    check("wr_rd", rd, 1'b0);
    check("wr_addr", haddr, 13'h1155);
    check("wr_data", wdata, 8'hA5);
    tick(1);
    check("wr_sel_end", sel, 1'b0);
    tick(3);
    n_vram_en = 1'b1;
    tb_drv    = 1'b0;
    tick(2);
    check("wr_pulses", sel_cnt - cnt0, 1);

    // Bank 3 window edges.
    host_write(1'b0, 1'b1, 11'h000, 8'h03);
    host_write(1'b1, 1'b0, 11'h000, 8'h11);
    check("b3_lo_addr", last_addr, 13'h1800);
    check("b3_lo_rd", last_rd, 1'b0);
    host_write(1'b1, 1'b0, 11'h7FF, 8'h22);
    check("b3_hi_addr", last_addr, 13'h1FFF);
    check("b3_hi_data", last_wdata, 8'h22);

    // VRAM read in bank 1 at 0x7FF.
    host_write(1'b0, 1'b1, 11'h000, 8'h01);
    cnt0      = sel_cnt;
    n_vram_en = 1'b0;
    addr      = 11'h7FF;
    n_rmem    = 1'b0;
    #1;
    check("rd_dir_fast", dir, 1'b0);
    tick(3);
    check("rd_sel", sel, 1'b1);
    check("rd_rd", rd, 1'b1);
    check("rd_addr", haddr, 13'h0FFF);
    tick(2);
    check("rd_bus_5clk", bus, 8'h5A);
    tick(3);
    check("rd_bus_hold", bus, 8'h5A);
    n_rmem = 1'b1;
    #1;
    check("rd_dir_release", dir, 1'b1);
    tick(4);
    n_vram_en = 1'b1;
    check("rd_pulses", sel_cnt - cnt0, 1);

    // Simultaneous read and write strobes are ignored.
    cnt0      = sel_cnt;
    n_vram_en = 1'b0;
    n_rmem    = 1'b0;
    n_wmem    = 1'b0;
    tick(8);
    n_rmem    = 1'b1;
    n_wmem    = 1'b1;
    tick(5);
    n_vram_en = 1'b1;
    tick(1);
    check("conflict_pulses", sel_cnt - cnt0, 0);

    // Both selects low on a write: goes to VRAM, bank untouched.
    cnt0 = sel_cnt;
    n_bank_en = 1'b0;
    host_write(1'b1, 1'b1, 11'h010, 8'h02);
    check("both_en_pulses", sel_cnt - cnt0, 1);
    check("both_en_addr", last_addr, 13'h0810);
    host_read(1'b0, 1'b1, 11'h000, rv, rdir);
    check("both_en_bank", rv, 8'h01);

    // Sub-cycle read glitch: pins turn around, no access generated.
    cnt0      = sel_cnt;
    n_vram_en = 1'b0;
    @(negedge clk);
    n_rmem = 1'b0;
    #1;
    check("glitch_dir_lo", dir, 1'b0);
    #1;
    n_rmem = 1'b1;
    #1;
    check("glitch_dir_hi", dir, 1'b1);
    tick(6);
    n_vram_en = 1'b1;
    check("glitch_pulses", sel_cnt - cnt0, 0);

    // Reset during the read select cycle.
    n_vram_en = 1'b0;
    addr      = 11'h123;
    n_rmem    = 1'b0;
    seen      = 1'b0;
    for (int i = 0; i < 10; i++) begin
      tick(1);
      if (sel) begin
        seen = 1'b1;
        break;
      end
    end
    check("rst_mid_seen", seen, 1'b1);
    nrst = 1'b0;
    #1;
    check("rst_mid_sel", sel, 1'b0);
    check("rst_mid_rd", rd, 1'b1);
    n_rmem    = 1'b1;
    n_vram_en = 1'b1;
    tick(2);
    nrst = 1'b1;
    tick(1);
    check("rst_mid_dir", dir, 1'b1);
    host_read(1'b0, 1'b1, 11'h000, rv, rdir);
    check("rst_mid_bank", rv, 8'h00);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
